pwm_ramp_sequencer: RTL and testbench
=====================================

// Module: pwm_ramp_sequencer
// PURPOSE
//   Sequences the 8-bit PWM duty cycle between SPI-programmed values.
//   Sits between the SPI register file and pwm_peripheral.
//   On a start pulse it ramps duty_out from its current value to a target,
//   in fixed-size steps every (prescale+1) clocks. Channel enables pass
//   through to the PWM block, with optional gating on ramp completion.
// PARAMETERS
//   PRESCALE_W  16  width of cfg_prescale and of the internal tick counter
//   STEP_W      8   width of cfg_step (<= 8)
// PORTS
//   clk             in   1           system clock
//   rst_n           in   1           synchronous reset, active-low
//   cfg_target      in   8           duty target for ramp / direct load
//   cfg_step        in   STEP_W      duty increment per tick; 0 treated as 1
//   cfg_prescale    in   PRESCALE_W  tick period = cfg_prescale+1 clocks
//   start           in   1           1-cycle pulse: begin ramp (IDLE only)
//   abort           in   1           1-cycle pulse: stop ramp, hold duty
//   duty_wr         in   1           1-cycle pulse: duty_out <= cfg_target (IDLE only)
//   en_pwm_in       in   16          PWM-mode enables from register file
//   duty_out        out  8           to pwm_peripheral pwm_duty_cycle
//   en_pwm_out      out  16          to pwm_peripheral PWM-mode enables
//   busy            out  1           state != IDLE
//   done            out  1           1-cycle pulse, ramp reached target
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state IDLE; duty_out=0; tick counter=0.
//   busy=0, done=0, off_latch=0; en_pwm_out=en_pwm_in.
// - Reset wins over every other input, including mid-ramp.
// - FSM states: IDLE, RAMP, DONE.
// - IDLE:
//   - start at edge E0: latch cfg_target/step/prescale, counter<=0.
//     Goes to RAMP, or to DONE if latched target == duty_out.
//   - duty_wr: duty_out<=cfg_target next edge; state stays IDLE.
//   - Priority in IDLE: abort > start > duty_wr; lower ones are dropped.
// - RAMP:
//   - counter increments each edge.
//   - Edge with counter==latched prescale: counter<=0; duty_out moves one
//     step toward target. Arithmetic in 9 bits, clamped to target:
//     no overshoot, no wrap.
//   - First update at edge E(prescale+1), then every prescale+1 edges.
//   - prescale=0 gives an update every clock.
//   - Update that lands duty_out==target: state<=DONE on the same edge.
//   - abort: state<=IDLE, duty_out holds, no done; takes precedence over a
//     coincident step update.
//   - start and duty_wr ignored. cfg_* changes ignored (latched copies).
// - DONE: done=1 for exactly this one cycle; next edge -> IDLE.
//   start/duty_wr in DONE are ignored.
// - done and busy are registered state decodes, no combinational input path.
// - Latched step of 0 is treated as 1.
// CONFIGURATION
// - RAMP_AUTO_DISABLE_EN defined:
//   - off_latch<=1 when entering DONE with duty_out==0.
//   - off_latch clears on an accepted start or duty_wr, and on reset.
//   - en_pwm_out = off_latch ? 16'h0000 : en_pwm_in.
// - RAMP_AUTO_DISABLE_EN undefined: no off_latch logic; en_pwm_out=en_pwm_in.
// TESTING
// 1. Reset with en_pwm_in=16'hA5A5 -> duty_out=0, busy=0, done=0,
//    en_pwm_out=16'hA5A5.
// 2. duty 0x00, start with target 0x10, step 4, prescale 3 -> duty_out
//    0x04/0x08/0x0C/0x10 at E4/E8/E12/E16; done high one cycle after E16;
//    busy low after E17.
// 3. duty 0x00, target 0x0A, step 4, prescale 0 -> 0x04, 0x08, 0x0A (clamp).
//    duty 0xFF, target 0x00, step 0x60 -> 0x9F, 0x3F, 0x00 (no wrap).
// 4. abort at E6 during ramp of test 2 -> duty_out holds 0x04, IDLE, no done.
//    start+abort same cycle in IDLE -> no ramp.
//    start with target==duty_out -> done after 1 cycle, duty unchanged.
// 5. rst_n low mid-ramp at duty 0x08 -> next edge duty_out=0, IDLE.
//    duty_wr during RAMP ignored; duty_wr in IDLE with 0x33 -> duty_out=0x33.
// 6. RAMP_AUTO_DISABLE_EN defined: ramp to 0x00 -> en_pwm_out=0 from
//    DONE onward. duty_wr with 0x40 -> en_pwm_out=en_pwm_in again.
//    Undefined: en_pwm_out always equals en_pwm_in.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Ramps the PWM duty cycle toward a programmed target in clamped steps and passes channel enables through.
// Latency: first duty update cfg_prescale+1 edges after the start edge; done/busy are registered state decodes.
// Backpressure: none; start/duty_wr/abort are single-cycle pulses and are dropped when not accepted.
// Optional macro RAMP_AUTO_DISABLE_EN: force en_pwm_out to zero after a ramp that finishes at duty 0.
module pwm_ramp_sequencer #(
  parameter int PRESCALE_W = 16,
  parameter int STEP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg_target,
  input  logic [STEP_W-1:0]     cfg_step,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  duty_wr,
  input  logic [15:0]           en_pwm_in,
  output logic [7:0]            duty_out,
  output logic [15:0]           en_pwm_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [7:0]            tgt_l;
  logic [STEP_W-1:0]     step_l;
  logic [PRESCALE_W-1:0] ps_l;
  logic [PRESCALE_W-1:0] cnt;

  logic [8:0] step_9;
  logic [8:0] up_sum;
  logic [8:0] dn_diff;
  logic [7:0] duty_next;
  logic       start_acc;
  logic       wr_acc;
  logic       tick;
  logic       enter_done;
  logic       off_set;

  // Accepted-command decode and one clamped step toward the latched target.
  // The 9-bit sum/difference exposes carry and borrow so the step never wraps.
  always_comb begin
    start_acc = (state == S_IDLE) && !abort && start;
    wr_acc    = (state == S_IDLE) && !abort && !start && duty_wr;
    tick      = (state == S_RAMP) && !abort && (cnt == ps_l);

    step_9 = 9'(step_l);
    if (step_l == '0) begin
      step_9 = 9'd1;
    end
    up_sum  = {1'b0, duty_out} + step_9;
    dn_diff = {1'b0, duty_out} - step_9;

    duty_next = tgt_l;
    if (duty_out < tgt_l) begin
      if (up_sum < {1'b0, tgt_l}) begin
        duty_next = up_sum[7:0];
      end
    end else begin
      if (!dn_diff[8] && (dn_diff[7:0] > tgt_l)) begin
        duty_next = dn_diff[7:0];
      end
    end

    enter_done = (start_acc && (cfg_target == duty_out)) ||
                 (tick && (duty_next == tgt_l));
    // Both entry paths land exactly on the target, so the target tells us the duty.
    off_set    = enter_done && (start_acc ? (cfg_target == 8'h00) : (tgt_l == 8'h00));
  end

  // Main sequencer: state, latched config, tick counter, duty and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tgt_l    <= '0;
      step_l   <= '0;
      ps_l     <= '0;
      cnt      <= '0;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            tgt_l  <= cfg_target;
            step_l <= cfg_step;
            ps_l   <= cfg_prescale;
            cnt    <= '0;
            busy   <= 1'b1;
            if (enter_done) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RAMP;
              done  <= 1'b0;
            end
          end else if (wr_acc) begin
            duty_out <= cfg_target;
          end
        end
        S_RAMP: begin
          if (abort) begin
            // Abort beats a coincident step: duty holds where it is.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (tick) begin
            cnt      <= '0;
            duty_out <= duty_next;
            if (enter_done) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAMP_AUTO_DISABLE_EN
  logic off_latch;

  // Kill the PWM enables once a ramp has brought the duty to zero; a new command re-arms them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_latch <= 1'b0;
    end else if (off_set) begin
      off_latch <= 1'b1;
    end else if (start_acc || wr_acc) begin
      off_latch <= 1'b0;
    end
  end

  assign en_pwm_out = off_latch ? 16'h0000 : en_pwm_in;
`else
  logic unused_off;
  assign unused_off = off_set;
  assign en_pwm_out = en_pwm_in;
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: stimulus pushes expected duty/done events with their edge number,
// a monitor pops one per observed change of duty_out or done pulse; status outputs are checked inline.
// Define RAMP_AUTO_DISABLE_EN when building the design with that option.
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_target = 8'h00;
  logic [7:0]  cfg_step = 8'h00;
  logic [15:0] cfg_prescale = 16'h0000;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        duty_wr = 1'b0;
  logic [15:0] en_pwm_in = 16'h0000;
  logic [7:0]  duty_out;
  logic [15:0] en_pwm_out;
  logic        busy;
  logic        done;

`ifdef RAMP_AUTO_DISABLE_EN
  localparam bit AUTO_OFF = 1'b1;
`else
  localparam bit AUTO_OFF = 1'b0;
`endif

  pwm_ramp_sequencer #(.PRESCALE_W(16), .STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .cfg_prescale(cfg_prescale),
    .start(start), .abort(abort), .duty_wr(duty_wr),
    .en_pwm_in(en_pwm_in), .duty_out(duty_out), .en_pwm_out(en_pwm_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       dn;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_duty = 8'h00;

  // Monitor: every duty change or done pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((duty_out !== prev_duty) || (done === 1'b1)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d duty=%h done=%b required no event", cyc, duty_out, done);
        end else begin
          e = q.pop_front();
          if ((e.c != cyc) || (e.d !== duty_out) || (e.dn !== done)) begin
            errors++;
            $display("FAIL event actual cyc=%0d duty=%h done=%b required cyc=%0d duty=%h done=%b",
                     cyc, duty_out, done, e.c, e.d, e.dn);
          end
        end
      end
      prev_duty = duty_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic expect_ev(input int c, input logic [7:0] d, input logic dn);
    exp_t x;
    x.c = c; x.d = d; x.dn = dn;
    q.push_back(x);
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse; cfg is scrambled afterwards to show the DUT uses latched copies.
  task automatic do_start(input logic [7:0] t, input logic [7:0] s, input logic [15:0] p, output int e0);
    cfg_target = t; cfg_step = s; cfg_prescale = p;
    start = 1'b1;
    step_clk(1);
    start = 1'b0;
    e0 = cyc;
    cfg_target = ~t; cfg_step = 8'h01; cfg_prescale = 16'h0007;
  endtask

  task automatic do_wr(input logic [7:0] t, output int e0);
    cfg_target = t;
    duty_wr = 1'b1;
    step_clk(1);
    duty_wr = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    int e0;
    // 1: reset state
    en_pwm_in = 16'hA5A5;
    rst_n = 1'b0;
    step_clk(3);
    chk("rst_duty", 32'(duty_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_en", 32'(en_pwm_out), 32'hA5A5);
    prev_duty = duty_out;
    mon_en = 1'b1;
    rst_n = 1'b1;
    step_clk(1);

    // 2: 0x00 -> 0x10, step 4, prescale 3
    do_start(8'h10, 8'h04, 16'd3, e0);
    expect_ev(e0 + 4, 8'h04, 1'b0);
    expect_ev(e0 + 8, 8'h08, 1'b0);
    expect_ev(e0 + 12, 8'h0C, 1'b0);
    expect_ev(e0 + 16, 8'h10, 1'b1);
    step_clk(15);
    chk("t2_busy_mid", 32'(busy), 32'h1);
    step_clk(1);
    chk("t2_done_e16", 32'(done), 32'h1);
    step_clk(1);
    chk("t2_busy_e17", 32'(busy), 32'h0);
    chk("t2_done_e17", 32'(done), 32'h0);

    // 3a: clamp on the way up
    do_wr(8'h00, e0);
    expect_ev(e0, 8'h00, 1'b0);
    do_start(8'h0A, 8'h04, 16'd0, e0);
    expect_ev(e0 + 1, 8'h04, 1'b0);
    expect_ev(e0 + 2, 8'h08, 1'b0);
    expect_ev(e0 + 3, 8'h0A, 1'b1);
    step_clk(5);

    // 3b: no wrap on the way down
    do_wr(8'hFF, e0);
    expect_ev(e0, 8'hFF, 1'b0);
    do_start(8'h00, 8'h60, 16'd0, e0);
    expect_ev(e0 + 1, 8'h9F, 1'b0);
    expect_ev(e0 + 2, 8'h3F, 1'b0);
    expect_ev(e0 + 3, 8'h00, 1'b1);
    step_clk(3);
    chk("t3_en_after_zero", 32'(en_pwm_out), AUTO_OFF ? 32'h0 : 32'hA5A5);
    step_clk(2);

    // 4a: abort at E6 holds duty, no done
    do_start(8'h10, 8'h04, 16'd3, e0);
    expect_ev(e0 + 4, 8'h04, 1'b0);
    step_clk(5);
    abort = 1'b1;
    step_clk(1);
    abort = 1'b0;
    chk("t4_abort_busy", 32'(busy), 32'h0);
    step_clk(10);
    chk("t4_abort_duty", 32'(duty_out), 32'h04);
    chk("t4_en_rearmed", 32'(en_pwm_out), 32'hA5A5);

    // 4b: start and abort together in IDLE
    cfg_target = 8'h20; cfg_step = 8'h04; cfg_prescale = 16'd0;
    start = 1'b1; abort = 1'b1;
    step_clk(1);
    start = 1'b0; abort = 1'b0;
    chk("t4_start_abort_busy", 32'(busy), 32'h0);
    step_clk(5);
    chk("t4_start_abort_duty", 32'(duty_out), 32'h04);

    // 4c: target already reached
    do_start(8'h04, 8'h04, 16'd3, e0);
    expect_ev(e0, 8'h04, 1'b0 | 1'b1);
    chk("t4_eq_busy", 32'(busy), 32'h1);
    step_clk(1);
    chk("t4_eq_busy_after", 32'(busy), 32'h0);
    chk("t4_eq_done_after", 32'(done), 32'h0);

    // 5a: reset mid-ramp, duty_wr during ramp ignored
    do_wr(8'h00, e0);
    expect_ev(e0, 8'h00, 1'b0);
    do_start(8'h10, 8'h04, 16'd3, e0);
    expect_ev(e0 + 4, 8'h04, 1'b0);
    expect_ev(e0 + 8, 8'h08, 1'b0);
    step_clk(4);
    cfg_target = 8'h33;
    duty_wr = 1'b1;
    step_clk(1);
    duty_wr = 1'b0;
    step_clk(4);
    chk("t5_duty_before_rst", 32'(duty_out), 32'h08);
    rst_n = 1'b0;
    expect_ev(e0 + 10, 8'h00, 1'b0);
    step_clk(1);
    chk("t5_rst_duty", 32'(duty_out), 32'h00);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step_clk(6);
    chk("t5_idle_after_rst", 32'(busy), 32'h0);

    // 5b: direct load in IDLE
    do_wr(8'h33, e0);
    expect_ev(e0, 8'h33, 1'b0);
    step_clk(1);
    chk("t5_wr_duty", 32'(duty_out), 32'h33);

    // 6: auto-disable of enables after ramping to zero
    en_pwm_in = 16'h5A3C;
    do_wr(8'h08, e0);
    expect_ev(e0, 8'h08, 1'b0);
    do_start(8'h00, 8'h08, 16'd1, e0);
    expect_ev(e0 + 2, 8'h00, 1'b1);
    step_clk(2);
    chk("t6_en_done", 32'(en_pwm_out), AUTO_OFF ? 32'h0 : 32'h5A3C);
    step_clk(3);
    chk("t6_en_idle", 32'(en_pwm_out), AUTO_OFF ? 32'h0 : 32'h5A3C);
    do_wr(8'h40, e0);
    expect_ev(e0, 8'h40, 1'b0);
    chk("t6_en_rearmed", 32'(en_pwm_out), 32'h5A3C);
    step_clk(3);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
